// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: edge-detected capture of data plus error flags into a FWFT circular FIFO.
// Optional macro UART_RX_FIFO_ERR_DROP_EN discards error frames and counts them in drop_count.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_parity_error,
    input  logic                  rx_stop_error,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_parity_error,
    output logic                  rd_stop_error,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic [7:0]            drop_count
);

    localparam int                ENTRY_W  = DATA_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [ENTRY_W-1:0]    head;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  valid_q;
    logic                  wr_req;
    logic                  store_req;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ovr_set;

    // A capture happens only on the rising edge of rx_valid, however long it is held.
    assign wr_req  = rx_valid & ~valid_q;
    assign rd_acc  = rd_en & ~empty;
    assign wr_acc  = store_req & (~full | rd_acc);
    assign ovr_set = store_req & full & ~rd_acc;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

`ifdef UART_RX_FIFO_ERR_DROP_EN
    logic err_frame;
    logic drop_req;

    assign err_frame = rx_parity_error | rx_stop_error;
    assign store_req = wr_req & ~err_frame;
    assign drop_req  = wr_req & err_frame;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= 8'd0;
        end else if (drop_req && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`else
    assign store_req  = wr_req;
    assign drop_count = 8'd0;
`endif

    // Control state: edge detector, pointers, occupancy, sticky overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            valid_q <= rx_valid;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    // Storage holds data only and is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= {rx_stop_error, rx_parity_error, rx_data};
        end
    end

    assign head            = empty ? '0 : mem[rd_ptr];
    assign rd_data         = head[DATA_WIDTH-1:0];
    assign rd_parity_error = head[DATA_WIDTH];
    assign rd_stop_error   = head[DATA_WIDTH+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table-driven vectors plus hand-written fill/overrun/reset sequences.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_error;
    logic       rx_stop_error;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_parity_error;
    logic       rd_stop_error;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       overrun_clr;
    logic [7:0] drop_count;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef UART_RX_FIFO_ERR_DROP_EN
    localparam bit ERR_DROP = 1'b1;
`else
    localparam bit ERR_DROP = 1'b0;
`endif

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_parity_error(rx_parity_error), .rx_stop_error(rx_stop_error),
        .rd_en(rd_en), .rd_data(rd_data), .rd_parity_error(rd_parity_error),
        .rd_stop_error(rd_stop_error), .empty(empty), .full(full), .count(count),
        .overrun(overrun), .overrun_clr(overrun_clr), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       pe;
        logic       se;
        logic       rd;
        logic       clr;
        logic [7:0] ed;
        logic       epe;
        logic       ese;
        logic       eempty;
        logic       efull;
        logic [4:0] ecnt;
        logic       eovr;
        logic [7:0] edrop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic pe, input logic se,
                                input logic rd, input logic clr, input logic [7:0] ed, input logic epe,
                                input logic ese, input logic eempty, input logic efull,
                                input logic [4:0] ecnt, input logic eovr, input logic [7:0] edrop);
        vec_t r;
        r.v = v; r.d = d; r.pe = pe; r.se = se; r.rd = rd; r.clr = clr;
        r.ed = ed; r.epe = epe; r.ese = ese; r.eempty = eempty; r.efull = efull;
        r.ecnt = ecnt; r.eovr = eovr; r.edrop = edrop;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] ed, input logic epe, input logic ese,
                               input logic eempty, input logic efull, input logic [4:0] ecnt,
                               input logic eovr, input logic [7:0] edrop);
        check({tag, ".rd_data"},   32'(rd_data),         32'(ed));
        check({tag, ".rd_perr"},   32'(rd_parity_error), 32'(epe));
        check({tag, ".rd_serr"},   32'(rd_stop_error),   32'(ese));
        check({tag, ".empty"},     32'(empty),           32'(eempty));
        check({tag, ".full"},      32'(full),            32'(efull));
        check({tag, ".count"},     32'(count),           32'(ecnt));
        check({tag, ".overrun"},   32'(overrun),         32'(eovr));
        check({tag, ".drop_count"}, 32'(drop_count),     32'(edrop));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        step();
        rx_valid = 1'b0;
        step();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0; rx_parity_error = 1'b0; rx_stop_error = 1'b0;
        rd_en = 1'b0; overrun_clr = 1'b0;
        step();
        step();
        check_state("reset", 8'h00, 0, 0, 1, 0, 5'd0, 0, 8'd0);
        reset = 1'b1;
        step();

        // v  d      pe se rd clr | ed   epe ese empty full cnt ovr drop
        tbl.push_back(mk(1, 8'h41, 0, 0, 0, 0, 8'h41, 0, 0, 0, 0, 5'd1, 0, 8'd0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h41, 0, 0, 0, 0, 5'd1, 0, 8'd0));
        tbl.push_back(mk(1, 8'h42, 0, 0, 0, 0, 8'h41, 0, 0, 0, 0, 5'd2, 0, 8'd0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h41, 0, 0, 0, 0, 5'd2, 0, 8'd0));
        tbl.push_back(mk(1, 8'h43, 0, 0, 0, 0, 8'h41, 0, 0, 0, 0, 5'd3, 0, 8'd0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h42, 0, 0, 0, 0, 5'd2, 0, 8'd0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h43, 0, 0, 0, 0, 5'd1, 0, 8'd0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 5'd0, 0, 8'd0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 5'd0, 0, 8'd0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 8'h5A, 0, 0, 0, 0, 8'h5A, 0, 0, 0, 0, 5'd1, 0, 8'd0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 5'd0, 0, 8'd0));
        if (ERR_DROP) begin
            tbl.push_back(mk(1, 8'h33, 1, 0, 0, 0, 8'h00, 0, 0, 1, 0, 5'd0, 0, 8'd1));
            tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 5'd0, 0, 8'd1));
            tbl.push_back(mk(1, 8'h34, 0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 5'd0, 0, 8'd2));
            tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 5'd0, 0, 8'd2));
        end else begin
            tbl.push_back(mk(1, 8'h33, 1, 0, 0, 0, 8'h33, 1, 0, 0, 0, 5'd1, 0, 8'd0));
            tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 5'd0, 0, 8'd0));
            tbl.push_back(mk(1, 8'h34, 0, 1, 0, 0, 8'h34, 0, 1, 0, 0, 5'd1, 0, 8'd0));
            tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 5'd0, 0, 8'd0));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            rx_valid = tbl[i].v; rx_data = tbl[i].d;
            rx_parity_error = tbl[i].pe; rx_stop_error = tbl[i].se;
            rd_en = tbl[i].rd; overrun_clr = tbl[i].clr;
            step();
            check_state($sformatf("vec%0d", i), tbl[i].ed, tbl[i].epe, tbl[i].ese, tbl[i].eempty,
                        tbl[i].efull, tbl[i].ecnt, tbl[i].eovr, tbl[i].edrop);
        end
        rx_valid = 1'b0; rx_parity_error = 1'b0; rx_stop_error = 1'b0; rd_en = 1'b0; overrun_clr = 1'b0;
        step();

        // Fill to full, overflow, clear, set-wins-over-clear, then write+read while full.
        for (int i = 0; i < 16; i++) write_word(8'(i));
        check("fill.full", 32'(full), 32'd1);
        check("fill.count", 32'(count), 32'd16);
        check("fill.head", 32'(rd_data), 32'h00);
        write_word(8'hFF);
        check("ovf.overrun", 32'(overrun), 32'd1);
        check("ovf.count", 32'(count), 32'd16);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("clr.overrun", 32'(overrun), 32'd0);
        rx_valid = 1'b1; rx_data = 8'hFE; overrun_clr = 1'b1;
        step();
        rx_valid = 1'b0; overrun_clr = 1'b0;
        check("setwins.overrun", 32'(overrun), 32'd1);
        check("setwins.count", 32'(count), 32'd16);
        step();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("clr2.overrun", 32'(overrun), 32'd0);
        rx_valid = 1'b1; rx_data = 8'hAA; rd_en = 1'b1;
        step();
        rx_valid = 1'b0; rd_en = 1'b0;
        check("wr_rd_full.overrun", 32'(overrun), 32'd0);
        check("wr_rd_full.count", 32'(count), 32'd16);
        check("wr_rd_full.head", 32'(rd_data), 32'h01);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain%0d", i), 32'(rd_data), 32'(i));
            pop();
        end
        check("drain.last", 32'(rd_data), 32'hAA);
        pop();
        check("drain.empty", 32'(empty), 32'd1);
        check("drain.count", 32'(count), 32'd0);

        // Reach count=7 with overrun still set, then assert reset asynchronously.
        for (int i = 0; i < 16; i++) write_word(8'(8'h10 + i));
        write_word(8'hFF);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("prerst%0d", i), 32'(rd_data), 32'(8'h10 + i));
            pop();
        end
        check("prerst.count", 32'(count), 32'd7);
        check("prerst.overrun", 32'(overrun), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_state("async_rst", 8'h00, 0, 0, 1, 0, 5'd0, 0, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        write_word(8'h77);
        check("post_rst.data", 32'(rd_data), 32'h77);
        check("post_rst.count", 32'(count), 32'd1);
        pop();
        check("post_rst.empty", 32'(empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
